alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  Producer side of the 64-bit ALU interface: decodes RV64 integer ALU instructions into
//  ALUCtl and operands A/B, and presents them to the EX-stage ALU via a valid/ready skid buffer.
//  Sits between register-file read and the ALU; full throughput (1 op/cycle), 1-cycle latency.
// PARAMETERS
//  XLEN      64  operand/data width; must match ALU A/B width
//  CTL_W     4   ALUCtl width
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  in_valid     in   1      upstream instruction + operands valid
//  in_ready     out  1      stage can accept (registered; = skid entry empty)
//  in_instr     in   32     RV64 instruction word
//  in_rs1_data  in   XLEN   rs1 register value
//  in_rs2_data  in   XLEN   rs2 register value
//  flush        in   1      kill all held entries (branch redirect)
//  out_valid    out  1      ALU operands valid
//  out_ready    in   1      ALU/EX stage accepts
//  out_a        out  XLEN   ALU operand A
//  out_b        out  XLEN   ALU operand B (rs2 or sign-extended imm)
//  out_alu_ctl  out  CTL_W  ALUCtl code
//  out_rd       out  5      destination register
//  out_illegal  out  1      instruction not executable by ALU
// BEHAVIOUR
//  - Reset: out_valid=0, out_a=0, out_b=0, out_alu_ctl=0, out_rd=0, out_illegal=0, in_ready=1.
//  - Two entries: main (drives out_*) and skid. Occupancy 0/1/2; in_ready=1 iff skid empty.
//  - Accept on in_valid&&in_ready; retire on out_valid&&out_ready. Accepted op visible on out_* next cycle.
//  - Simultaneous accept+retire at occupancy 1: new op loads main, occupancy stays 1.
//  - Accept at occupancy 1 with out_ready=0: op lands in skid, in_ready drops next cycle.
//  - Retire at occupancy 2: skid moves to main, in_ready returns to 1 next cycle.
//  - out_* held stable while out_valid&&!out_ready.
//  - flush: occupancy -> 0 next cycle, out_valid=0; beats any same-cycle accept (input discarded).
//  - Async reset mid-operation: all entries dropped immediately, outputs to reset values.
//  - Decode R-type (opcode 0110011), funct3/funct7 -> ALUCtl:
//    000/0000000 add 0010; 000/0100000 sub 0110; 001 sll 0011; 010 slt 0100; 100 xor 0111;
//    101/0000000 srl 1000; 101/0100000 sra 1010; 110 or 0001; 111 and 0000.
//  - A=rs1, B=rs2 for R-type. Shift amount is B[5:0] at ALU; stage passes B unmodified.
//  - Illegal (sltu, other funct7, other opcodes): out_illegal=1, out_alu_ctl=0010, A=B=0, rd=0;
//    still handshaken as a normal entry.
// CONFIGURATION
//  - ALU_IMM_OPS_EN defined: opcode 0010011 decoded: addi/slti/xori/ori/andi with
//    B = sign-extend(instr[31:20]) to XLEN; slli (funct6 000000), srli (000000), srai (010000)
//    with B = zero-extend(instr[25:20]); other funct6 -> illegal. sltiu -> illegal.
//  - Not defined: opcode 0010011 treated as illegal; no immediate mux synthesized.
// STRUCTURE
//  - Package alu_pkg: ALUCtl localparams (ALU_ADD..ALU_SRA), opcode and funct3/funct7 constants,
//    struct alu_issue_t {a, b, ctl, rd, illegal}.
//  - Sub-module alu_ctl_decode: combinational instr+rs data -> alu_issue_t; top holds skid logic.
// TESTING
//  - add x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid, ctl=0010, a=5, b=7, rd=3.
//  - sub/sra/sll/slt/xor/srl/or/and each once -> ctl 0110/1010/0011/0100/0111/1000/0001/0000.
//  - Backpressure: out_ready=0, 3 back-to-back inputs -> 2 held, in_ready=0 after 2nd; release -> order preserved.
//  - flush with occupancy 2 and in_valid=1 same cycle -> next cycle out_valid=0, in_ready=1, input dropped.
//  - sltu (funct3 011) -> out_illegal=1, ctl=0010, a=b=0; with ALU_IMM_OPS_EN addi x1,x0,-1 -> b=0xFFFF_FFFF_FFFF_FFFF.
//  - Assert rst_n low while occupancy 2 -> out_valid=0, in_ready=1 without a clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control codes, RV64 decode constants and the issue-entry type.
//   XLEN/CTL_W   operand and ALUCtl widths
//   ALU_*        ALUCtl codes presented to the EX-stage ALU
//   OP_/F3_/F7_/F6_  instruction field encodings used by the decoder
//   alu_issue_t  one decoded entry {a, b, ctl, rd, illegal}
//   funct3_ctl   funct3 (+ alternate-encoding bit) -> ALUCtl
package alu_pkg;
   localparam int XLEN  = 64;
   localparam int CTL_W = 4;

   localparam logic [CTL_W-1:0] ALU_AND = 4'b0000;
   localparam logic [CTL_W-1:0] ALU_OR  = 4'b0001;
   localparam logic [CTL_W-1:0] ALU_ADD = 4'b0010;
   localparam logic [CTL_W-1:0] ALU_SLL = 4'b0011;
   localparam logic [CTL_W-1:0] ALU_SLT = 4'b0100;
   localparam logic [CTL_W-1:0] ALU_SUB = 4'b0110;
   localparam logic [CTL_W-1:0] ALU_XOR = 4'b0111;
   localparam logic [CTL_W-1:0] ALU_SRL = 4'b1000;
   localparam logic [CTL_W-1:0] ALU_SRA = 4'b1010;

   localparam logic [6:0] OP_REG = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;

   localparam logic [2:0] F3_ADDSUB = 3'b000;
   localparam logic [2:0] F3_SLL    = 3'b001;
   localparam logic [2:0] F3_SLT    = 3'b010;
   localparam logic [2:0] F3_SLTU   = 3'b011;
   localparam logic [2:0] F3_XOR    = 3'b100;
   localparam logic [2:0] F3_SR     = 3'b101;
   localparam logic [2:0] F3_OR     = 3'b110;
   localparam logic [2:0] F3_AND    = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [5:0] F6_BASE = 6'b000000;
   localparam logic [5:0] F6_ALT  = 6'b010000;

   typedef struct packed {
      logic [XLEN-1:0]  a;
      logic [XLEN-1:0]  b;
      logic [CTL_W-1:0] ctl;
      logic [4:0]       rd;
      logic             illegal;
   } alu_issue_t;

   // alt selects sub over add and sra over srl; ignored for the other funct3 values
   function automatic logic [CTL_W-1:0] funct3_ctl(input logic [2:0] f3, input logic alt);
      case (f3)
         F3_ADDSUB: funct3_ctl = alt ? ALU_SUB : ALU_ADD;
         F3_SLL:    funct3_ctl = ALU_SLL;
         F3_SLT:    funct3_ctl = ALU_SLT;
         F3_XOR:    funct3_ctl = ALU_XOR;
         F3_SR:     funct3_ctl = alt ? ALU_SRA : ALU_SRL;
         F3_OR:     funct3_ctl = ALU_OR;
         F3_AND:    funct3_ctl = ALU_AND;
         default:   funct3_ctl = ALU_ADD;
      endcase
   endfunction
endpackage

// File: rtl/alu_ctl_decode.sv
// alu_ctl_decode: combinational RV64 integer-ALU decode of instr + register data into one issue entry.
//   instr     in   32    instruction word
//   rs1_data  in   XLEN  rs1 value (operand A)
//   rs2_data  in   XLEN  rs2 value (operand B for R-type)
//   dec       out        decoded entry; illegal entries carry ctl=ADD, a=b=0, rd=0
// Optional: ALU_IMM_OPS_EN adds OP-IMM decode (addi/slti/xori/ori/andi/slli/srli/srai).
module alu_ctl_decode
   import alu_pkg::*;
(
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   output alu_issue_t      dec
);
   logic [6:0]       opcode;
   logic [6:0]       funct7;
   logic [2:0]       funct3;
   logic             legal;
   logic [CTL_W-1:0] ctl;
   logic [XLEN-1:0]  opb;
   logic             unused_bits;

   assign opcode      = instr[6:0];
   assign funct3      = instr[14:12];
   assign funct7      = instr[31:25];
   // register-specifier fields are consumed by the register file, not here
   assign unused_bits = ^instr[24:15];

`ifdef ALU_IMM_OPS_EN
   logic [5:0] funct6;
   assign funct6 = instr[31:26];
`endif

   always_comb begin
      legal = 1'b0;
      ctl   = ALU_ADD;
      opb   = rs2_data;
      if (opcode == OP_REG) begin
         legal = (funct7 == F7_BASE && funct3 != F3_SLTU) ||
                 (funct7 == F7_ALT && (funct3 == F3_ADDSUB || funct3 == F3_SR));
         ctl   = funct3_ctl(funct3, funct7 == F7_ALT);
      end
`ifdef ALU_IMM_OPS_EN
      else if (opcode == OP_IMM) begin
         legal = funct3 == F3_SLL ? funct6 == F6_BASE :
                 funct3 == F3_SR  ? (funct6 == F6_BASE || funct6 == F6_ALT) :
                 funct3 != F3_SLTU;
         ctl   = funct3_ctl(funct3, funct3 == F3_SR && funct6 == F6_ALT);
         // shifts take a 6-bit unsigned shamt; everything else a sign-extended imm12
         opb   = (funct3 == F3_SLL || funct3 == F3_SR) ? XLEN'(instr[25:20]) :
                 {{(XLEN-12){instr[31]}}, instr[31:20]};
      end
`endif
      dec = legal ? '{a: rs1_data, b: opb, ctl: ctl, rd: instr[11:7], illegal: 1'b0}
                  : '{a: '0, b: '0, ctl: ALU_ADD, rd: '0, illegal: 1'b1};
   end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes RV64 ALU ops and issues them to the EX-stage ALU through a 2-entry skid buffer.
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready               upstream handshake; in_ready = skid entry empty
//   in_instr, in_rs1/rs2_data       instruction and register operands
//   flush                           drop all held entries (wins over a same-cycle accept)
//   out_valid/out_ready             downstream handshake
//   out_a/out_b/out_alu_ctl/out_rd/out_illegal  main-entry contents
// Optional: ALU_IMM_OPS_EN enables OP-IMM decode in alu_ctl_decode.
module alu_issue_stage
   import alu_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [XLEN-1:0]  in_rs1_data,
   input  logic [XLEN-1:0]  in_rs2_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_a,
   output logic [XLEN-1:0]  out_b,
   output logic [CTL_W-1:0] out_alu_ctl,
   output logic [4:0]       out_rd,
   output logic             out_illegal
);
   alu_issue_t dec;
   alu_issue_t main_q;
   alu_issue_t skid_q;
   logic [1:0] occ;
   logic       accept;
   logic       retire;

   alu_ctl_decode u_dec (
      .instr    (in_instr),
      .rs1_data (in_rs1_data),
      .rs2_data (in_rs2_data),
      .dec      (dec)
   );

   assign in_ready  = occ != 2'd2;
   assign out_valid = occ != 2'd0;
   assign accept    = in_valid && in_ready && !flush;
   assign retire    = out_valid && out_ready;

   // main always holds the oldest entry; skid only fills when main is stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ    <= 2'd0;
         main_q <= '0;
         skid_q <= '0;
      end else if (flush) begin
         occ <= 2'd0;
      end else if (occ == 2'd2 && retire) begin
         main_q <= skid_q;
         occ    <= 2'd1;
      end else if (accept) begin
         if (occ == 2'd0 || retire) main_q <= dec;
         else skid_q <= dec;
         occ <= (occ == 2'd1 && !retire) ? 2'd2 : 2'd1;
      end else if (retire) begin
         occ <= 2'd0;
      end
   end

   assign out_a       = main_q.a;
   assign out_b       = main_q.b;
   assign out_alu_ctl = main_q.ctl;
   assign out_rd      = main_q.rd;
   assign out_illegal = main_q.illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed and random checks of alu_issue_stage against a queue-based reference model.
module tb_alu_issue_stage;
   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic [3:0]  ctl;
      logic [4:0]  rd;
      logic        ill;
   } op_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [63:0] in_rs1_data;
   logic [63:0] in_rs2_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_a;
   logic [63:0] out_b;
   logic [3:0]  out_alu_ctl;
   logic [4:0]  out_rd;
   logic        out_illegal;

   int total = 0;
   int bad   = 0;
   op_t q[$];

   alu_issue_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .in_rs1_data (in_rs1_data),
      .in_rs2_data (in_rs2_data),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_a       (out_a),
      .out_b       (out_b),
      .out_alu_ctl (out_alu_ctl),
      .out_rd      (out_rd),
      .out_illegal (out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference decode: list every legal encoding explicitly, everything else is illegal.
   function automatic op_t ref_dec(input logic [31:0] ins, input logic [63:0] r1, input logic [63:0] r2);
      op_t o;
      logic [9:0] key;
      logic [5:0] f6;
      int c;
      c   = -1;
      key = {ins[31:25], ins[14:12]};
      f6  = ins[31:26];
      o.a = r1;
      o.b = r2;
      o.rd = ins[11:7];
      o.ill = 1'b0;
      if (ins[6:0] == 7'h33) begin
         case (key)
            10'b0000000_000: c = 2;
            10'b0100000_000: c = 6;
            10'b0000000_001: c = 3;
            10'b0000000_010: c = 4;
            10'b0000000_100: c = 7;
            10'b0000000_101: c = 8;
            10'b0100000_101: c = 10;
            10'b0000000_110: c = 1;
            10'b0000000_111: c = 0;
            default:         c = -1;
         endcase
      end
`ifdef ALU_IMM_OPS_EN
      else if (ins[6:0] == 7'h13) begin
         o.b = 64'($signed(ins[31:20]));
         case (ins[14:12])
            3'b000: c = 2;
            3'b010: c = 4;
            3'b100: c = 7;
            3'b110: c = 1;
            3'b111: c = 0;
            3'b001: c = (f6 == 6'd0) ? 3 : -1;
            3'b101: c = (f6 == 6'd0) ? 8 : (f6 == 6'd16) ? 10 : -1;
            default: c = -1;
         endcase
         if (ins[14:12] == 3'b001 || ins[14:12] == 3'b101) o.b = {58'd0, ins[25:20]};
      end
`endif
      if (c < 0) begin
         o = '{a: 64'd0, b: 64'd0, ctl: 4'd2, rd: 5'd0, ill: 1'b1};
      end else begin
         o.ctl = 4'(c);
      end
      return o;
   endfunction

   function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
      return {f7, 5'd2, 5'd1, f3, rd, 7'h33};
   endfunction

   function automatic logic [31:0] gen_instr();
      logic [31:0] w;
      logic [6:0]  f7s [3];
      int k;
      f7s[0] = 7'h00;
      f7s[1] = 7'h20;
      f7s[2] = 7'($urandom);
      w = $urandom;
      k = $urandom_range(0, 9);
      if (k <= 6) begin
         w[6:0]   = 7'h33;
         w[31:25] = f7s[k <= 3 ? 0 : (k <= 5 ? 1 : 2)];
      end else if (k <= 8) begin
         w[6:0] = 7'h13;
         if ($urandom_range(0, 1) == 1) w[31:26] = $urandom_range(0, 1) == 1 ? 6'd16 : 6'd0;
      end
      return w;
   endfunction

   // Model: FIFO of at most two entries; flush empties it and wins over a new input.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
      end else if (flush) begin
         q.delete();
      end else begin
         automatic bit acc = in_valid && q.size() < 2;
         automatic bit ret = q.size() > 0 && out_ready;
         automatic op_t n = ref_dec(in_instr, in_rs1_data, in_rs2_data);
         if (ret) void'(q.pop_front());
         if (acc) q.push_back(n);
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("m_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
         chk("m_in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
         if (q.size() > 0 && out_valid) begin
            chk("m_a", out_a, q[0].a);
            chk("m_b", out_b, q[0].b);
            chk("m_ctl", {60'd0, out_alu_ctl}, {60'd0, q[0].ctl});
            chk("m_rd", {59'd0, out_rd}, {59'd0, q[0].rd});
            chk("m_ill", {63'd0, out_illegal}, {63'd0, q[0].ill});
         end
      end
   end

   task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] r1, input logic [63:0] r2,
                        input logic ordy, input logic fl);
      in_valid    = v;
      in_instr    = ins;
      in_rs1_data = r1;
      in_rs2_data = r2;
      out_ready   = ordy;
      flush       = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [6:0] t_f7  [8];
   logic [2:0] t_f3  [8];
   logic [3:0] t_ctl [8];

   initial begin
      t_f7[0] = 7'h20; t_f3[0] = 3'b000; t_ctl[0] = 4'b0110;
      t_f7[1] = 7'h20; t_f3[1] = 3'b101; t_ctl[1] = 4'b1010;
      t_f7[2] = 7'h00; t_f3[2] = 3'b001; t_ctl[2] = 4'b0011;
      t_f7[3] = 7'h00; t_f3[3] = 3'b010; t_ctl[3] = 4'b0100;
      t_f7[4] = 7'h00; t_f3[4] = 3'b100; t_ctl[4] = 4'b0111;
      t_f7[5] = 7'h00; t_f3[5] = 3'b101; t_ctl[5] = 4'b1000;
      t_f7[6] = 7'h00; t_f3[6] = 3'b110; t_ctl[6] = 4'b0001;
      t_f7[7] = 7'h00; t_f3[7] = 3'b111; t_ctl[7] = 4'b0000;

      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_a", out_a, 64'd0);
      chk("rst_b", out_b, 64'd0);
      chk("rst_ctl", {60'd0, out_alu_ctl}, 64'd0);
      chk("rst_rd", {59'd0, out_rd}, 64'd0);
      chk("rst_ill", {63'd0, out_illegal}, 64'd0);

      drive(1, 32'h002081B3, 64'd5, 64'd7, 1, 0);
      tick();
      chk("add_valid", {63'd0, out_valid}, 64'd1);
      chk("add_ctl", {60'd0, out_alu_ctl}, 64'h2);
      chk("add_a", out_a, 64'd5);
      chk("add_b", out_b, 64'd7);
      chk("add_rd", {59'd0, out_rd}, 64'd3);

      for (int i = 0; i < 8; i++) begin
         drive(1, rtype(t_f7[i], t_f3[i], 5'(i + 1)), 64'd100 + 64'(i), 64'd3, 1, 0);
         tick();
         chk("op_ctl", {60'd0, out_alu_ctl}, {60'd0, t_ctl[i]});
         chk("op_rd", {59'd0, out_rd}, 64'(i + 1));
      end
      drive(0, 0, 0, 0, 1, 0);
      tick();

      for (int i = 0; i < 3; i++) begin
         drive(1, rtype(7'h00, 3'b000, 5'(10 + i)), 64'(i), 64'(i), 0, 0);
         tick();
         chk("bp_in_ready", {63'd0, in_ready}, i == 0 ? 64'd1 : 64'd0);
         chk("bp_hold_rd", {59'd0, out_rd}, 64'd10);
      end
      drive(0, 0, 0, 0, 1, 0);
      tick();
      chk("bp_rel_rd", {59'd0, out_rd}, 64'd11);
      chk("bp_rel_in_ready", {63'd0, in_ready}, 64'd1);
      tick();
      chk("bp_empty", {63'd0, out_valid}, 64'd0);

      for (int i = 0; i < 2; i++) begin
         drive(1, rtype(7'h00, 3'b111, 5'(20 + i)), 64'd1, 64'd1, 0, 0);
         tick();
      end
      drive(1, rtype(7'h00, 3'b110, 5'd22), 64'd1, 64'd1, 0, 1);
      tick();
      chk("fl_valid", {63'd0, out_valid}, 64'd0);
      chk("fl_in_ready", {63'd0, in_ready}, 64'd1);
      drive(0, 0, 0, 0, 1, 0);
      tick();
      chk("fl_dropped", {63'd0, out_valid}, 64'd0);

      drive(1, rtype(7'h00, 3'b011, 5'd5), 64'd9, 64'd9, 1, 0);
      tick();
      chk("sltu_ill", {63'd0, out_illegal}, 64'd1);
      chk("sltu_ctl", {60'd0, out_alu_ctl}, 64'h2);
      chk("sltu_a", out_a, 64'd0);
      chk("sltu_b", out_b, 64'd0);
      chk("sltu_rd", {59'd0, out_rd}, 64'd0);
`ifdef ALU_IMM_OPS_EN
      drive(1, 32'hFFF00093, 64'd0, 64'd0, 1, 0);
      tick();
      chk("addi_b", out_b, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("addi_ctl", {60'd0, out_alu_ctl}, 64'h2);
      chk("addi_ill", {63'd0, out_illegal}, 64'd0);
`else
      drive(1, 32'hFFF00093, 64'd4, 64'd4, 1, 0);
      tick();
      chk("opimm_off_ill", {63'd0, out_illegal}, 64'd1);
`endif
      drive(0, 0, 0, 0, 1, 0);
      tick();

      for (int i = 0; i < 2; i++) begin
         drive(1, rtype(7'h00, 3'b100, 5'(25 + i)), 64'd6, 64'd6, 0, 0);
         tick();
      end
      drive(0, 0, 0, 0, 0, 0);
      chk("ar_pre_in_ready", {63'd0, in_ready}, 64'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_valid", {63'd0, out_valid}, 64'd0);
      chk("ar_in_ready", {63'd0, in_ready}, 64'd1);
      chk("ar_rd", {59'd0, out_rd}, 64'd0);
      tick();
      rst_n = 1'b1;

      repeat (3000) begin
         drive($urandom_range(0, 9) < 7, gen_instr(), {$urandom, $urandom}, {$urandom, $urandom},
               $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
         tick();
      end
      drive(0, 0, 0, 0, 1, 0);
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
